// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display blocks.
package seg7_pkg;

  // Scan FSM states: all anodes off (GAP) or one digit lit (DRIVE).
  typedef enum logic [0:0] {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } state_e;

  // Active-low segment bus value with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7.sv
// Hex nibble to active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}.
module seg7 (
  input  logic [3:0] in,
  output logic [6:0] out
);

  // Pure combinational lookup of the glyph for each hex value.
  always_comb begin
    out = 7'h7F;
    case (in)
      4'h0: out = 7'h40;
      4'h1: out = 7'h79;
      4'h2: out = 7'h24;
      4'h3: out = 7'h30;
      4'h4: out = 7'h19;
      4'h5: out = 7'h12;
      4'h6: out = 7'h02;
      4'h7: out = 7'h78;
      4'h8: out = 7'h00;
      4'h9: out = 7'h10;
      4'hA: out = 7'h08;
      4'hB: out = 7'h03;
      4'hC: out = 7'h46;
      4'hD: out = 7'h21;
      4'hE: out = 7'h06;
      4'hF: out = 7'h0E;
      default: out = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller: digit register file, GAP/DRIVE scan FSM
// with a shared down-counter, and registered anode/segment outputs.
//
// Handshake: there is none beyond a plain write strobe. A cycle with load=1
// and an in-range load_addr writes load_data at that rising edge; there is
// no ready/backpressure, every strobe is accepted or (out of range) dropped.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 1000,
  parameter int GAP_CYCLES   = 8,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [AW-1:0]         load_addr,
  input  logic [3:0]            load_data,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [6:0]            out,
  output logic [NUM_DIGITS-1:0] an,
  output logic [AW-1:0]         digit_idx,
  output logic                  frame_tick,
  output logic                  dbg_state
);

  localparam int MAXC = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DRIVE_LOAD = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  logic [3:0]    entry [NUM_DIGITS];
  state_e        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx;
  logic [6:0]    decoded;

  assign digit_idx = idx;
  assign dbg_state = (state == DRIVE);

  // The one shared decoder always looks at the digit being scanned.
  seg7 u_seg7 (
    .in  (entry[idx]),
    .out (decoded)
  );

  // Register file: in-range writes land at the edge, others are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) entry[i] <= 4'h0;
    end else if (load && (int'(load_addr) < NUM_DIGITS)) begin
      entry[load_addr] <= load_data;
    end
  end

  // Scan FSM: count down each phase, advance the digit when DRIVE ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= GAP;
      cnt   <= GAP_LOAD;
      idx   <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (state == GAP) begin
      state <= DRIVE;
      cnt   <= DRIVE_LOAD;
    end else begin
      state <= GAP;
      cnt   <= GAP_LOAD;
      idx   <= (idx == LAST_IDX) ? '0 : idx + AW'(1);
    end
  end

  // Output registers follow the current state one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      out        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (state == DRIVE) && (cnt == '0) && (idx == LAST_IDX);
      if (state == GAP) begin
        an  <= '1;
        out <= SEG_OFF;
      end else begin
        an  <= ~(ONE_HOT0 << idx);
        out <= blank_mask[idx] ? SEG_OFF : decoded;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-accurate reference model driven by the
// position within the frame, plus directed corner sequences.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int G     = 2;
  localparam int SLOT  = G + D;
  localparam int FRAME = N * SLOT;

  typedef struct packed {
    logic [3:0] nib;
    logic [6:0] seg;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       load = 1'b0;
  logic [1:0] load_addr = '0;
  logic [3:0] load_data = '0;
  logic [3:0] blank_mask = '0;
  logic [6:0] out;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_tick;
  logic       dbg_state;

  logic       load3 = 1'b0;
  logic [1:0] load_addr3 = 2'd3;
  logic [3:0] load_data3 = '0;
  logic [6:0] out3;
  logic [2:0] an3;
  logic [1:0] digit_idx3;
  logic       frame_tick3;
  logic       dbg_state3;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DRIVE_CYCLES(D), .GAP_CYCLES(G)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .blank_mask (blank_mask),
    .out        (out),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(3), .DRIVE_CYCLES(D), .GAP_CYCLES(G)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .load       (load3),
    .load_addr  (load_addr3),
    .load_data  (load_data3),
    .blank_mask (3'b000),
    .out        (out3),
    .an         (an3),
    .digit_idx  (digit_idx3),
    .frame_tick (frame_tick3),
    .dbg_state  (dbg_state3)
  );

  // ---------------- model state / scoreboard ----------------
  vec_t       vecs [16];
  logic [3:0] m_ent [N];
  int         k;
  logic [3:0] e_an;
  logic [6:0] e_out;
  logic       e_tick;
  logic [1:0] e_idx;
  logic       e_st;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         chk3_en = 1'b0;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    return vecs[n].seg;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // One clock: model the edge from frame position, then compare #1 later.
  task automatic step();
    int p;
    int slot;
    @(posedge clk);
    if (reset) begin
      k = 0;
      for (int i = 0; i < N; i++) m_ent[i] = 4'h0;
      e_an = 4'hF; e_out = 7'h7F; e_tick = 1'b0; e_idx = 2'd0; e_st = 1'b0;
    end else begin
      k++;
      p    = (k - 1) % FRAME;
      slot = p / SLOT;
      if ((p % SLOT) < G) begin
        e_an  = 4'hF;
        e_out = 7'h7F;
      end else begin
        e_an  = ~(4'b0001 << slot);
        e_out = blank_mask[slot] ? 7'h7F : seg_of(m_ent[slot]);
      end
      e_tick = ((k % FRAME) == 0);
      p      = k % FRAME;
      e_idx  = 2'(p / SLOT);
      e_st   = ((p % SLOT) >= G);
      if (load) m_ent[load_addr] = load_data;
    end
    #1;
    chk("an", an, e_an);
    chk("out", out, e_out);
    chk("frame_tick", frame_tick, e_tick);
    chk("digit_idx", digit_idx, e_idx);
    chk("state", dbg_state, e_st);
    if (chk3_en && an3 !== 3'b111) chk("n3_invalid_write", out3, 7'h40);
    load3      = ($urandom_range(0, 1) == 1);
    load_data3 = 4'($urandom);
  endtask

  task automatic wait_an(input logic [3:0] tgt);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (an !== tgt && n < 3 * FRAME);
    chk("wait_an", an, tgt);
  endtask

  task automatic load_digits(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
    logic [3:0] vals [4];
    vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; load_addr = 2'(i); load_data = vals[i];
      step();
    end
    load = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79};
    vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
    vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12};
    vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h78};
    vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10};
    vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
    vecs[12] = '{4'hC, 7'h46}; vecs[13] = '{4'hD, 7'h21};
    vecs[14] = '{4'hE, 7'h06}; vecs[15] = '{4'hF, 7'h0E};

    // Reset then idle: gap, first lit digit, periodic frame ticks.
    reset = 1'b1;
    step();
    step();
    chk3_en = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4; i++) step();

    // Digits 1..4 shown in order across a full frame.
    load_digits(4'h1, 4'h2, 4'h3, 4'h4);
    for (int i = 0; i < FRAME + 6; i++) step();

    // Decoder table: each glyph reaches its slot.
    for (int i = 0; i < 16; i++) begin
      load = 1'b1; load_addr = 2'(i % 4); load_data = vecs[i].nib;
      step();
      load = 1'b0;
      wait_an(~(4'b0001 << (i % 4)));
      chk("table_seg", out, vecs[i].seg);
    end

    // Write to the digit currently lit: new glyph one cycle after the write edge.
    load_digits(4'h1, 4'h2, 4'h3, 4'h4);
    wait_an(4'b1011);
    load = 1'b1; load_addr = 2'd2; load_data = 4'hF;
    step();
    load = 1'b0;
    chk("live_write_old", out, 7'h30);
    step();
    chk("live_write_new", out, 7'h0E);
    chk("live_write_an", an, 4'b1011);

    // Blank mask hides slots 0 and 2 while anodes still scan.
    blank_mask = 4'b0101;
    wait_an(4'b1110);
    chk("blank_slot0", out, 7'h7F);
    wait_an(4'b1101);
    chk("unblank_slot1", out, 7'h24);
    wait_an(4'b1011);
    chk("blank_slot2", out, 7'h7F);
    wait_an(4'b0111);
    chk("unblank_slot3", out, 7'h19);
    blank_mask = 4'b0000;

    // Random loads and blank changes against the model.
    for (int i = 0; i < 500; i++) begin
      load      = ($urandom_range(0, 2) == 0);
      load_addr = 2'($urandom_range(0, 3));
      load_data = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
      step();
    end
    load = 1'b0;
    blank_mask = 4'b0000;

    // Reset in the middle of digit 3's lit time.
    load_digits(4'h1, 4'h2, 4'h3, 4'h4);
    wait_an(4'b0111);
    step();
    reset = 1'b1;
    step();
    chk("midreset_an", an, 4'hF);
    chk("midreset_out", out, 7'h7F);
    chk("midreset_idx", digit_idx, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      step();
      if (an !== 4'hF) chk("cleared_entry", out, 7'h40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
